program_memory_arbiter: RTL and testbench

Round-robin arbiter that shares read port A of the program memory between up to `NUM_REQ` instruction/data consumers, e.g. CPU fetch, CPU constant loads and a debug/DMA reader. It sits between the consumers and the `program_memory_bus` CONSUMER_A modport. Each cycle it grants at most one read. It tracks the owner of every in-flight read through a tag pipeline matched to the memory's fixed read latency, and routes each returning word to the requester that issued it.

---
 rtl/program_memory_arbiter.sv | 113 +++++++++++
 tb/tb_program_memory_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_arbiter.sv
// Round-robin read-port arbiter for program memory port A.
// Grants at most one consumer read per cycle and tags each grant with its owner.
// Each returning word is routed back to the consumer that issued the read.
module program_memory_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    grant_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_data,
  output logic [31:0]             mem_addr,
  output logic                    mem_read_request,
  input  logic [31:0]             mem_instr,
  input  logic                    mem_data_valid,
  output logic                    err_orphan
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LAST   = LATENCY - 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [LATENCY-1:0] tag_vld;
  logic [PTR_W-1:0]   tag_idx [LATENCY];
  logic               orphan_c;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [CNT_W-1:0] cand;
    logic [PTR_W-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CNT_W'(k);
      if (cand >= CNT_W'(NUM_REQ)) begin
        cand = cand - CNT_W'(NUM_REQ);
      end
      cand_idx = PTR_W'(cand);
      if (grant_en && !grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Grant fan-out and memory request drive
  always_comb begin
    req_ready = '0;
    mem_addr  = '0;
    if (grant_any) begin
      req_ready = NUM_REQ'(1) << grant_idx;
      mem_addr  = req_addr[ADDR_W*grant_idx +: ADDR_W];
    end
    mem_read_request = |(req_valid & req_ready);
  end

  // Pointer moves one past the winner; holds when nothing is granted
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_nxt = '0;
      end else begin
        rr_ptr_nxt = grant_idx + PTR_W'(1);
      end
    end
  end

  // Route the returning word using the oldest tag; flag any valid/tag mismatch
  always_comb begin
    resp_data  = mem_instr;
    resp_valid = '0;
    if (mem_data_valid && tag_vld[LAST]) begin
      resp_valid = NUM_REQ'(1) << tag_idx[LAST];
    end
    orphan_c = mem_data_valid ^ tag_vld[LAST];
  end

  // Pointer, free-running tag pipeline and sticky orphan flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr     <= '0;
      tag_vld    <= '0;
      err_orphan <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      tag_vld[0] <= grant_any;
      tag_idx[0] <= grant_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      if (orphan_c) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter with a 2-cycle program memory model.
module tb_program_memory_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        grant_en;
  logic [2:0]  req_valid;
  logic [95:0] req_addr;
  logic [2:0]  req_ready;
  logic [2:0]  resp_valid;
  logic [31:0] resp_data;
  logic [31:0] mem_addr;
  logic        mem_read_request;
  logic [31:0] mem_instr;
  logic        mem_data_valid;
  logic        err_orphan;
  logic        inject = 1'b0;
  logic        suppress = 1'b0;

  logic [1:0]  p_v = '0;
  logic [31:0] p_a0 = '0;
  logic [31:0] p_a1 = '0;

  int n_total = 0;
  int n_pass  = 0;

  program_memory_arbiter #(.NUM_REQ(3), .LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .grant_en(grant_en),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .mem_addr(mem_addr),
    .mem_read_request(mem_read_request), .mem_instr(mem_instr),
    .mem_data_valid(mem_data_valid), .err_orphan(err_orphan)
  );

  always #5 clk_in = ~clk_in;

  // Program memory: word = 0xC0DE0000 | word index, valid two cycles after request
  always @(posedge clk_in) begin
    if (rst_in) begin
      p_v  <= '0;
      p_a0 <= '0;
      p_a1 <= '0;
    end else begin
      p_v  <= {p_v[0], mem_read_request};
      p_a0 <= mem_addr;
      p_a1 <= p_a0;
    end
  end
  assign mem_instr      = 32'hC0DE_0000 | (p_a1 >> 2);
  assign mem_data_valid = (p_v[1] & ~suppress) | inject;

  typedef struct {
    logic        rst;
    logic        gen;
    logic [2:0]  valid;
    logic [95:0] addr;
    logic [2:0]  ready;
    logic [31:0] maddr;
    logic [2:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic gen, input logic [2:0] valid,
                              input logic [95:0] addr, input logic [2:0] ready,
                              input logic [31:0] maddr, input logic [2:0] resp,
                              input logic [31:0] data);
    vec_t v;
    v.rst = rst; v.gen = gen; v.valid = valid; v.addr = addr;
    v.ready = ready; v.maddr = maddr; v.resp = resp; v.data = data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic rst, input logic gen, input logic [2:0] valid,
                      input logic [95:0] addr, input logic inj = 1'b0, input logic sup = 1'b0);
    @(negedge clk_in);
    rst_in = rst; grant_en = gen; req_valid = valid; req_addr = addr;
    inject = inj; suppress = sup;
    #1;
  endtask

  localparam logic [95:0] A1 = {32'h8, 32'h10, 32'h0};
  localparam logic [95:0] A2 = {32'h8, 32'h4,  32'h0};
  localparam logic [31:0] W0 = 32'hC0DE_0000;
  localparam logic [31:0] W1 = 32'hC0DE_0001;
  localparam logic [31:0] W2 = 32'hC0DE_0002;
  localparam logic [31:0] W4 = 32'hC0DE_0004;

  initial begin
    rst_in = 1'b1; grant_en = 1'b0; req_valid = '0; req_addr = '0;

    // single requester
    vecs.push_back(mk(1, 1, 3'b000, A1, 3'b000, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b010, A1, 3'b010, 32'h10, 3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b000, A1, 3'b000, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b000, A1, 3'b000, 32'h0,  3'b010, W4));
    // all three valid for nine cycles
    vecs.push_back(mk(1, 1, 3'b000, A2, 3'b000, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b001, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b010, 32'h4,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b100, 32'h8,  3'b001, W0));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b001, 32'h0,  3'b010, W1));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b010, 32'h4,  3'b100, W2));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b100, 32'h8,  3'b001, W0));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b001, 32'h0,  3'b010, W1));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b010, 32'h4,  3'b100, W2));
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b100, 32'h8,  3'b001, W0));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b010, W1));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b100, W2));
    // pointer rotation
    vecs.push_back(mk(0, 1, 3'b010, A2, 3'b010, 32'h4,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b101, A2, 3'b100, 32'h8,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b001, A2, 3'b001, 32'h0,  3'b010, W1));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b100, W2));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b001, W0));
    vecs.push_back(mk(0, 1, 3'b100, A2, 3'b100, 32'h8,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b011, A2, 3'b001, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b010, A2, 3'b010, 32'h4,  3'b100, W2));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b001, W0));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b010, W1));
    // grant_en drop with two reads in flight, then restore
    vecs.push_back(mk(0, 1, 3'b111, A2, 3'b100, 32'h8,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b011, A2, 3'b001, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 0, 3'b011, A2, 3'b000, 32'h0,  3'b100, W2));
    vecs.push_back(mk(0, 0, 3'b011, A2, 3'b000, 32'h0,  3'b001, W0));
    vecs.push_back(mk(0, 0, 3'b011, A2, 3'b000, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b011, A2, 3'b010, 32'h4,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b000, 0));
    vecs.push_back(mk(0, 1, 3'b000, A2, 3'b000, 32'h0,  3'b010, W1));

    // reset values
    step(1, 0, 3'b000, '0);
    step(1, 0, 3'b000, '0);
    check("reset ready", 32'(req_ready), 32'(3'b000));
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset read_request", 32'(mem_read_request), 32'h0);
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_data", resp_data, W0);
    check("reset err_orphan", 32'(err_orphan), 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].gen, vecs[i].valid, vecs[i].addr);
      check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
      check($sformatf("v%0d read_request", i), 32'(mem_read_request), 32'(|vecs[i].ready));
      check($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].resp));
      if (vecs[i].resp != 3'b000)
        check($sformatf("v%0d resp_data", i), resp_data, vecs[i].data);
      check($sformatf("v%0d err_orphan", i), 32'(err_orphan), 32'h0);
    end

    // reset one cycle after a grant drops the in-flight read quietly
    step(0, 1, 3'b010, A2);
    check("midrst grant", 32'(req_ready), 32'(3'b010));
    step(1, 1, 3'b000, A2);
    check("midrst resp0", 32'(resp_valid), 32'h0);
    step(0, 1, 3'b000, A2);
    check("midrst resp1", 32'(resp_valid), 32'h0);
    check("midrst orphan1", 32'(err_orphan), 32'h0);
    step(0, 1, 3'b000, A2);
    check("midrst resp2", 32'(resp_valid), 32'h0);
    check("midrst orphan2", 32'(err_orphan), 32'h0);
    step(0, 1, 3'b011, A2);
    check("midrst ptr0", 32'(req_ready), 32'(3'b001));
    step(0, 1, 3'b000, A2);
    step(0, 1, 3'b000, A2);
    check("midrst later resp", 32'(resp_valid), 32'(3'b001));
    check("midrst later data", resp_data, W0);
    check("midrst later orphan", 32'(err_orphan), 32'h0);

    // data_valid with nothing outstanding
    step(0, 1, 3'b000, A2, 1'b1);
    check("inject resp", 32'(resp_valid), 32'h0);
    check("inject orphan same cycle", 32'(err_orphan), 32'h0);
    step(0, 1, 3'b000, A2);
    check("inject orphan set", 32'(err_orphan), 32'h1);
    check("inject resp after", 32'(resp_valid), 32'h0);
    step(0, 1, 3'b000, A2);
    check("inject orphan sticky", 32'(err_orphan), 32'h1);
    step(1, 1, 3'b000, A2);
    check("inject orphan in reset cycle", 32'(err_orphan), 32'h1);
    step(0, 1, 3'b000, A2);
    check("inject orphan cleared", 32'(err_orphan), 32'h0);

    // outstanding tag whose data never arrives
    step(0, 1, 3'b001, A2);
    check("lost grant", 32'(req_ready), 32'(3'b001));
    step(0, 1, 3'b000, A2);
    step(0, 1, 3'b000, A2, 1'b0, 1'b1);
    check("lost resp", 32'(resp_valid), 32'h0);
    check("lost orphan same cycle", 32'(err_orphan), 32'h0);
    step(0, 1, 3'b000, A2);
    check("lost orphan set", 32'(err_orphan), 32'h1);
    step(1, 1, 3'b000, A2);
    step(0, 1, 3'b000, A2);
    check("lost orphan cleared", 32'(err_orphan), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
